// File: rtl/tpu_pkg.sv
// Shared types and constants for the TPU datapath blocks.
// Holds the outbound DMA frame state type and framing constants.
package tpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    DATA,
    CSUM
  } out_state_t;

  localparam int unsigned NUM_WORDS_DEF = 4;
  localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;
  localparam int unsigned FRAME_BEATS = NUM_WORDS_DEF + 2;

endpackage

// File: rtl/result_out_dma.sv
// Outbound result DMA: snapshots the result matrix on ext and
// streams header, data bytes and XOR checksum to the host.
module result_out_dma
  import tpu_pkg::*;
#(
  parameter int unsigned NUM_WORDS = NUM_WORDS_DEF,
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] HEADER_BYTE = HEADER_BYTE_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            ext,
  input  logic [NUM_WORDS*DATA_WIDTH-1:0] res_words,
  input  logic                            host_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  output logic                            busy,
  output logic                            done,
  output logic                            overrun
);

  localparam int unsigned IW =
    (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

  out_state_t state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NUM_WORDS*DATA_WIDTH-1:0] snap_q, snap_d;
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
  logic done_q, done_d;
  logic overrun_q, overrun_d;
  logic [DATA_WIDTH-1:0] cur_word;

  // Select the snapshot word addressed by idx.
  always_comb begin
    cur_word = '0;
    for (int i = 0; i < int'(NUM_WORDS); i++) begin
      if (idx_q == IW'(i)) begin
        cur_word = snap_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Beat presented to the host in the current state.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    unique case (state_q)
      IDLE: begin
        out_valid = 1'b0;
        out_data  = '0;
      end
      HEADER: begin
        out_valid = 1'b1;
        out_data  = HEADER_BYTE;
      end
      DATA: begin
        out_valid = 1'b1;
        out_data  = cur_word;
      end
      CSUM: begin
        out_valid = 1'b1;
        out_data  = csum_q;
      end
      default: begin
        out_valid = 1'b0;
        out_data  = '0;
      end
    endcase
  end

  // Frame sequencing; every transition waits for an accepted beat.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    csum_d    = csum_q;
    done_d    = 1'b0;
    overrun_d = overrun_q | (ext & (state_q != IDLE));
    unique case (state_q)
      IDLE: begin
        if (ext) begin
          snap_d  = res_words;
          csum_d  = '0;
          state_d = HEADER;
        end
      end
      HEADER: begin
        if (host_ready) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (host_ready) begin
          csum_d = csum_q ^ cur_word;
          if (idx_q == LAST_IDX) begin
            state_d = CSUM;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      CSUM: begin
        if (host_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      snap_q    <= '0;
      csum_q    <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      csum_q    <= csum_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_result_out_dma.sv
// Self-checking bench for result_out_dma: beat-queue reference
// model compared every cycle, plus literal frame checks.
module tb_result_out_dma;

  logic        clk = 1'b0;
  logic        reset;
  logic        ext;
  logic [31:0] res_words;
  logic        host_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic        overrun;

  int tests = 0;
  int fails = 0;

  logic [7:0] mq[$];
  logic [7:0] seen_q[$];
  logic done_m = 1'b0;
  logic ovr_m = 1'b0;

  result_out_dma dut (
    .clk(clk),
    .reset(reset),
    .ext(ext),
    .res_words(res_words),
    .host_ready(host_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .busy(busy),
    .done(done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Reference model: a frame is a queue of beats still owed.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      done_m = 1'b0;
      ovr_m  = 1'b0;
    end else begin
      done_m = 1'b0;
      if (mq.size() != 0) begin
        if (ext) ovr_m = 1'b1;
        if (host_ready) begin
          void'(mq.pop_front());
          if (mq.size() == 0) done_m = 1'b1;
        end
      end else if (ext) begin
        logic [7:0] x;
        x = 8'h00;
        mq.push_back(8'hA5);
        for (int i = 0; i < 4; i++) begin
          mq.push_back(res_words[i*8 +: 8]);
          x = x ^ res_words[i*8 +: 8];
        end
        mq.push_back(x);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset) begin
      logic [7:0] ed;
      logic ev;
      ev = (mq.size() != 0);
      ed = ev ? mq[0] : 8'h00;
      chk("cycle {valid,data,busy,done,ovr}",
          {20'd0, out_valid, out_data, busy, done, overrun},
          {20'd0, ev, ed, ev, done_m, ovr_m});
      if (out_valid && host_ready) seen_q.push_back(out_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input string name, input int lim);
    int n;
    n = 0;
    while (!done && n < lim) begin
      cyc();
      n++;
    end
    chk({name, " done seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic chk_seen(input string name, input logic [7:0] e[$]);
    chk({name, " beat count"}, seen_q.size(), e.size());
    for (int i = 0; i < e.size() && i < seen_q.size(); i++)
      chk({name, " beat"}, {24'd0, seen_q[i]}, {24'd0, e[i]});
  endtask

  task automatic basic_frame(input string name);
    logic [7:0] e[6];
    e = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    res_words = 32'h44332211;
    host_ready = 1'b1;
    ext = 1'b1;
    cyc();
    ext = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk({name, " seq"}, {23'd0, out_valid, out_data},
          {23'd0, 1'b1, e[k]});
    end
    @(negedge clk);
    chk({name, " done N+7"}, {31'd0, done}, 32'd1);
    @(negedge clk);
    chk({name, " idle after"}, {30'd0, busy, out_valid}, 32'd0);
    #1;
  endtask

  initial begin
    logic [7:0] e[$];
    reset = 1'b1;
    ext = 1'b0;
    host_ready = 1'b0;
    res_words = 32'h0;
    #1;
    chk("reset state", {20'd0, out_valid, out_data, busy, done, overrun},
        32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc();

    basic_frame("basic");

    // Backpressure for three cycles on the 22 beat.
    seen_q.delete();
    res_words = 32'h44332211;
    host_ready = 1'b1;
    ext = 1'b1;
    cyc();
    ext = 1'b0;
    cyc();
    cyc();
    host_ready = 1'b0;
    cyc();
    @(negedge clk);
    chk("stall holds 22", {23'd0, out_valid, out_data},
        {23'd0, 1'b1, 8'h22});
    cyc();
    cyc();
    host_ready = 1'b1;
    repeat (4) cyc();
    @(negedge clk);
    chk("backpressure done N+10", {31'd0, done}, 32'd1);
    #1;
    e = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    chk_seen("backpressure", e);

    // Snapshot isolation and overrun.
    cyc();
    seen_q.delete();
    ext = 1'b1;
    cyc();
    ext = 1'b0;
    res_words = 32'hFFFFFFFF;
    cyc();
    cyc();
    ext = 1'b1;
    cyc();
    ext = 1'b0;
    wait_done("snapshot", 20);
    repeat (4) cyc();
    chk("overrun sticky", {31'd0, overrun}, 32'd1);
    chk("no second frame", {31'd0, busy}, 32'd0);
    chk_seen("snapshot", e);

    // Back-to-back with ext held.
    seen_q.delete();
    res_words = 32'h04030201;
    ext = 1'b1;
    repeat (8) cyc();
    ext = 1'b0;
    wait_done("b2b", 20);
    cyc();
    e = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04,
          8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
    chk_seen("b2b", e);

    // Asynchronous reset during the 33 beat.
    res_words = 32'h44332211;
    ext = 1'b1;
    cyc();
    ext = 1'b0;
    repeat (3) cyc();
    #2;
    reset = 1'b1;
    #1;
    chk("async reset", {29'd0, out_valid, busy, overrun}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cyc();
    basic_frame("after reset");

    // Randomised traffic.
    for (int c = 0; c < 3000; c++) begin
      ext = ($urandom_range(0, 9) == 0);
      host_ready = ($urandom_range(0, 3) != 0);
      res_words = $urandom;
      cyc();
    end
    ext = 1'b0;
    host_ready = 1'b1;
    repeat (10) cyc();
    chk("drain idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
